// File: rtl/cpu_clock_sequencer_pkg.sv
// clock_pkg: default sequencer geometry and RUN/HOLD state encoding
package clock_pkg;
  localparam int DEF_PHASES = 12;
  localparam int DEF_RESET_PHASE = 3;
  localparam int DEF_Q_PHASE = 0;
  localparam int DEF_E_PHASE = 3;
  localparam int DEF_QN_PHASE = 6;
  localparam int DEF_EN_PHASE = 9;
  localparam int DEF_DIV_A = 2;
  localparam int DEF_DIV_B = 3;
  localparam logic [0:0] RUN = 1'b0;
  localparam logic [0:0] HOLD = 1'b1;
endpackage

// File: rtl/cpu_clock_sequencer_phase_ring.sv
// phase_ring: one-hot rotating ring that advances only when asked
module phase_ring #(
  parameter int PHASES = 12,
  parameter int RESET_PHASE = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              advance,
  output logic [PHASES-1:0] ring,
  output logic [PHASES-1:0] ring_next
);
  assign ring_next = advance ? {ring[PHASES-2:0], ring[PHASES-1]} : ring;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) ring <= PHASES'(1) << RESET_PHASE;
    else ring <= ring_next;
endmodule

// File: rtl/cpu_clock_sequencer.sv
// cpu_clock_sequencer: holdable CPU Q/E phase enables plus free-running divider enables
module cpu_clock_sequencer
  import clock_pkg::*;
#(
  parameter int PHASES = DEF_PHASES,
  parameter int RESET_PHASE = DEF_RESET_PHASE,
  parameter int Q_PHASE = DEF_Q_PHASE,
  parameter int E_PHASE = DEF_E_PHASE,
  parameter int QN_PHASE = DEF_QN_PHASE,
  parameter int EN_PHASE = DEF_EN_PHASE,
  parameter int DIV_A = DEF_DIV_A,
  parameter int DIV_B = DEF_DIV_B,
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              halt_req,
  output logic              halt_ack,
  output logic              en_q,
  output logic              en_e,
  output logic              en_q_n,
  output logic              en_e_n,
  output logic              en_a,
  output logic              en_b,
  output logic [PHASES-1:0] phase,
  output logic [PHASES-1:0] phase_next,
  output logic [CNT_W-1:0]  cycle_count
);
  if (PHASES < 4 || PHASES % DIV_A != 0 || PHASES % DIV_B != 0 || RESET_PHASE >= PHASES ||
      Q_PHASE >= PHASES || E_PHASE >= PHASES || QN_PHASE >= PHASES || EN_PHASE >= PHASES ||
      DIV_A < 1 || DIV_B < 1) begin : g_bad_params
    $error("cpu_clock_sequencer: illegal parameter set");
  end
  function automatic logic [PHASES-1:0] div_mask(int div, int rem);
    div_mask = '0;
    for (int i = 0; i < PHASES; i++) div_mask[i] = (i % div) == rem;
  endfunction
  localparam logic [PHASES-1:0] MASK_A = div_mask(DIV_A, DIV_A - 1);
  localparam logic [PHASES-1:0] MASK_B = div_mask(DIV_B, 0);
  logic [0:0]        state;
  logic              cpu_adv;
  logic [PHASES-1:0] free;
  // the last index is where the bus cycle may be stretched
  assign cpu_adv  = (state == HOLD) ? !halt_req : !(phase[PHASES-1] && halt_req);
  assign halt_ack = (state == HOLD);
  phase_ring #(.PHASES(PHASES), .RESET_PHASE(RESET_PHASE)) u_cpu_ring (
    .clk(clk), .rst_n(rst_n), .advance(cpu_adv), .ring(phase), .ring_next(phase_next)
  );
  phase_ring #(.PHASES(PHASES), .RESET_PHASE(RESET_PHASE)) u_free_ring (
    .clk(clk), .rst_n(rst_n), .advance(1'b1), .ring(free), .ring_next()
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state       <= RUN;
      en_q        <= 1'b0;
      en_e        <= 1'b0;
      en_q_n      <= 1'b0;
      en_e_n      <= 1'b0;
      en_a        <= 1'b0;
      en_b        <= 1'b0;
      cycle_count <= '0;
    end else begin
      state       <= cpu_adv ? RUN : HOLD;
      en_q        <= cpu_adv && phase[Q_PHASE];
      en_e        <= cpu_adv && phase[E_PHASE];
      en_q_n      <= cpu_adv && phase[QN_PHASE];
      en_e_n      <= cpu_adv && phase[EN_PHASE];
      en_a        <= |(free & MASK_A);
      en_b        <= |(free & MASK_B);
      cycle_count <= cycle_count + CNT_W'(cpu_adv && phase[PHASES-1]);
    end
endmodule

// File: tb/tb_cpu_clock_sequencer.sv
// tb_cpu_clock_sequencer: random halt traffic on default and 8-phase/4-bit instances vs an index-level model
module tb_cpu_clock_sequencer;
  typedef struct {
    int cpu, fr, cnt;
    bit hold, q, e, qn, en, a, b;
  } model_t;
  logic clk = 1'b0, rst_n = 1'b0, halt_req = 1'b0;
  logic d_ack, d_q, d_e, d_qn, d_en, d_a, d_b;
  logic [11:0] d_phase, d_phase_next;
  logic [15:0] d_cnt;
  logic s_ack, s_q, s_e, s_qn, s_en, s_a, s_b;
  logic [7:0] s_phase, s_phase_next;
  logic [3:0] s_cnt;
  int checks = 0, errors = 0;
  model_t md, ms;
  always #5 clk = ~clk;
  cpu_clock_sequencer dut (
    .clk(clk), .rst_n(rst_n), .halt_req(halt_req), .halt_ack(d_ack),
    .en_q(d_q), .en_e(d_e), .en_q_n(d_qn), .en_e_n(d_en), .en_a(d_a), .en_b(d_b),
    .phase(d_phase), .phase_next(d_phase_next), .cycle_count(d_cnt)
  );
  cpu_clock_sequencer #(.PHASES(8), .RESET_PHASE(3), .Q_PHASE(0), .E_PHASE(2), .QN_PHASE(4),
    .EN_PHASE(6), .DIV_A(2), .DIV_B(4), .CNT_W(4)) dut8 (
    .clk(clk), .rst_n(rst_n), .halt_req(halt_req), .halt_ack(s_ack),
    .en_q(s_q), .en_e(s_e), .en_q_n(s_qn), .en_e_n(s_en), .en_a(s_a), .en_b(s_b),
    .phase(s_phase), .phase_next(s_phase_next), .cycle_count(s_cnt)
  );
  function automatic model_t reset_model();
    model_t m;
    m.cpu = 3; m.fr = 3; m.cnt = 0; m.hold = 0;
    m.q = 0; m.e = 0; m.qn = 0; m.en = 0; m.a = 0; m.b = 0;
    return m;
  endfunction
  function automatic bit advances(model_t m, bit h, int p);
    return m.hold ? !h : !(m.cpu == p - 1 && h);
  endfunction
  function automatic model_t step(model_t m, bit h, int p, int qp, int ep, int qnp, int enp,
                                  int da, int db, int modulus);
    model_t n;
    bit adv = advances(m, h, p);
    n.q = adv && m.cpu == qp;
    n.e = adv && m.cpu == ep;
    n.qn = adv && m.cpu == qnp;
    n.en = adv && m.cpu == enp;
    n.a = (m.fr % da) == da - 1;
    n.b = (m.fr % db) == 0;
    n.cnt = (adv && m.cpu == p - 1) ? (m.cnt + 1) % modulus : m.cnt;
    n.hold = !adv;
    n.cpu = adv ? (m.cpu + 1) % p : m.cpu;
    n.fr = (m.fr + 1) % p;
    return n;
  endfunction
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic check_all();
    check("dflt_flags", 64'({d_ack, d_q, d_e, d_qn, d_en, d_a, d_b}),
          64'({md.hold, md.q, md.e, md.qn, md.en, md.a, md.b}));
    check("dflt_phase", 64'(d_phase), 64'(1) << md.cpu);
    check("dflt_phase_next", 64'(d_phase_next),
          64'(1) << (advances(md, halt_req, 12) ? (md.cpu + 1) % 12 : md.cpu));
    check("dflt_count", 64'(d_cnt), 64'(md.cnt));
    check("p8_flags", 64'({s_ack, s_q, s_e, s_qn, s_en, s_a, s_b}),
          64'({ms.hold, ms.q, ms.e, ms.qn, ms.en, ms.a, ms.b}));
    check("p8_phase", 64'(s_phase), 64'(1) << ms.cpu);
    check("p8_phase_next", 64'(s_phase_next),
          64'(1) << (advances(ms, halt_req, 8) ? (ms.cpu + 1) % 8 : ms.cpu));
    check("p8_count", 64'(s_cnt), 64'(ms.cnt));
  endtask
  task automatic tick(input bit h);
    halt_req = h;
    @(posedge clk);
    md = step(md, h, 12, 0, 3, 6, 9, 2, 3, 65536);
    ms = step(ms, h, 8, 0, 2, 4, 6, 2, 4, 16);
    @(negedge clk);
    check_all();
  endtask
  initial begin
    md = reset_model();
    ms = reset_model();
    #12;
    check_all();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 120; i++) tick(1'b0);
    check("dflt_count_120", 64'(d_cnt), 64'd10);
    while (md.cpu != 8) tick(1'b0);
    for (int i = 0; i < 20; i++) tick(1'b1);
    for (int i = 0; i < 30; i++) tick(1'b0);
    while (md.cpu != 5) tick(1'b0);
    tick(1'b1);
    for (int i = 0; i < 30; i++) tick(1'b0);
    for (int i = 0; i < 600; i++) tick($urandom_range(0, 3) == 0);
    for (int i = 0; i < 16; i++) tick(1'b1);
    check("dflt_in_hold", 64'(d_ack), 64'd1);
    #2;
    rst_n = 1'b0;
    md = reset_model();
    ms = reset_model();
    #1;
    check_all();
    @(negedge clk);
    check_all();
    halt_req = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 200; i++) tick(1'b0);
    for (int i = 0; i < 400; i++) tick($urandom_range(0, 1) == 1);
    for (int i = 0; i < 40; i++) tick(1'b0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
